// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the cache-to-burst-memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int LINE_BITS_DEF  = 256;
    localparam int BEAT_BITS_DEF  = 64;
    localparam int ADDR_WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CMD  = 3'd1,
        RD_WAIT = 3'd2,
        WR_BEAT = 3'd3,
        RESP    = 3'd4
    } arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } requester_t;

    typedef logic [LINE_BITS_DEF-1:0] line_t;
    typedef logic [BEAT_BITS_DEF-1:0] beat_t;

    // Round robin: on a tie the requester that did not win last time goes first.
    function automatic requester_t rr_pick(input logic i_req, input logic d_req,
                                           input requester_t last);
        requester_t pick;
        if (i_req && d_req) begin
            pick = (last == ICACHE) ? DCACHE : ICACHE;
        end else if (i_req) begin
            pick = ICACHE;
        end else begin
            pick = DCACHE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_chk.sv
// Protocol monitor: latches a sticky flag when the dcache raises read and write together.
module mem_port_arbiter_chk (
    input  logic clk,
    input  logic rst,
    input  logic d_read,
    input  logic d_write,
    output logic proto_err
);

    logic proto_err_r;

    // Sticky record of a simultaneous dcache read and writeback request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err_r <= 1'b0;
        end else if (d_read && d_write) begin
            proto_err_r <= 1'b1;
        end else begin
            proto_err_r <= proto_err_r;
        end
    end

    assign proto_err = proto_err_r;

endmodule

// File: rtl/mem_port_arbiter_line_deserializer.sv
// Beat counter plus line register; read beats are dropped into their slot by count.
module mem_port_arbiter_line_deserializer
    import mem_port_arbiter_pkg::*;
#(
    parameter int LINE_BITS = LINE_BITS_DEF,
    parameter int BEAT_BITS = BEAT_BITS_DEF
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     clear,
    input  logic                                     load,
    input  logic                                     step,
    input  logic [BEAT_BITS-1:0]                     beat,
    output logic [$clog2(LINE_BITS/BEAT_BITS)-1:0]   beat_cnt,
    output logic [LINE_BITS-1:0]                     line
);

    localparam int CNT_W = $clog2(LINE_BITS / BEAT_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]     beat_cnt_r;
    logic [LINE_BITS-1:0] line_r;

    // Count beats (wrapping) and capture loaded beats into the addressed slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_r <= {CNT_W{1'b0}};
            line_r     <= {LINE_BITS{1'b0}};
        end else if (clear) begin
            beat_cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            line_r[beat_cnt_r*BEAT_BITS +: BEAT_BITS] <= beat;
            beat_cnt_r <= beat_cnt_r + CNT_ONE;
        end else if (step) begin
            beat_cnt_r <= beat_cnt_r + CNT_ONE;
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    assign beat_cnt = beat_cnt_r;
    assign line     = line_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates icache/dcache line requests onto one 4-beat burst memory port.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LINE_BITS  = LINE_BITS_DEF,
    parameter int BEAT_BITS  = BEAT_BITS_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    output logic [LINE_BITS-1:0]  i_rdata,
    output logic                  i_resp,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_BITS-1:0]  d_wdata,
    output logic [LINE_BITS-1:0]  d_rdata,
    output logic                  d_resp,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_BITS-1:0]  bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [BEAT_BITS-1:0]  bmem_rdata,
    input  logic                  bmem_rvalid
);

    localparam int BEATS    = LINE_BITS / BEAT_BITS;
    localparam int CNT_W    = $clog2(BEATS);
    localparam int OFFSET_W = $clog2(LINE_BITS / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        {{(ADDR_WIDTH-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    arb_state_t            state_r, next_state_s;
    requester_t            last_grant_r, grant_s;
    logic                  op_write_r;
    logic [ADDR_WIDTH-1:0] bmem_addr_r;
    logic                  bmem_read_r, bmem_write_r;
    logic [BEAT_BITS-1:0]  bmem_wdata_r;
    logic                  i_resp_r, d_resp_r;
    logic                  latch_s, clear_s, load_s, step_s;
    logic [CNT_W-1:0]      beat_cnt_s, wr_cnt_next_s;
    logic [LINE_BITS-1:0]  line_s;

    mem_port_arbiter_line_deserializer #(
        .LINE_BITS (LINE_BITS),
        .BEAT_BITS (BEAT_BITS)
    ) u_deser (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_s),
        .load     (load_s),
        .step     (step_s),
        .beat     (bmem_rdata),
        .beat_cnt (beat_cnt_s),
        .line     (line_s)
    );

    // Next-state decode; wr_cnt_next_s lets the write beat be registered one cycle early.
    always_comb begin
        next_state_s  = state_r;
        grant_s       = rr_pick(i_read, d_read | d_write, last_grant_r);
        latch_s       = 1'b0;
        clear_s       = 1'b0;
        load_s        = 1'b0;
        step_s        = 1'b0;
        wr_cnt_next_s = beat_cnt_s;
        case (state_r)
            IDLE: begin
                clear_s       = 1'b1;
                wr_cnt_next_s = {CNT_W{1'b0}};
                if (i_read || d_read || d_write) begin
                    latch_s = 1'b1;
                    if ((grant_s == DCACHE) && d_write) begin
                        next_state_s = WR_BEAT;
                    end else begin
                        next_state_s = RD_CMD;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD_CMD: begin
                clear_s = 1'b1;
                if (bmem_ready) begin
                    next_state_s = RD_WAIT;
                end else begin
                    next_state_s = RD_CMD;
                end
            end
            RD_WAIT: begin
                load_s = bmem_rvalid;
                if (bmem_rvalid && (beat_cnt_s == LAST_BEAT)) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = RD_WAIT;
                end
            end
            WR_BEAT: begin
                step_s = bmem_ready;
                if (bmem_ready) begin
                    wr_cnt_next_s = beat_cnt_s + CNT_ONE;
                    next_state_s  = (beat_cnt_s == LAST_BEAT) ? RESP : WR_BEAT;
                end else begin
                    next_state_s  = WR_BEAT;
                end
            end
            RESP: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, grant bookkeeping and outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= DCACHE;
            op_write_r   <= 1'b0;
            bmem_addr_r  <= {ADDR_WIDTH{1'b0}};
            bmem_read_r  <= 1'b0;
            bmem_write_r <= 1'b0;
            bmem_wdata_r <= {BEAT_BITS{1'b0}};
            i_resp_r     <= 1'b0;
            d_resp_r     <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (latch_s) begin
                last_grant_r <= grant_s;
                op_write_r   <= (grant_s == DCACHE) && d_write;
                bmem_addr_r  <= ((grant_s == ICACHE) ? i_addr : d_addr) & ALIGN_MASK;
            end else begin
                last_grant_r <= last_grant_r;
                op_write_r   <= op_write_r;
                bmem_addr_r  <= bmem_addr_r;
            end
            bmem_read_r  <= (next_state_s == RD_CMD);
            bmem_write_r <= (next_state_s == WR_BEAT);
            bmem_wdata_r <= (next_state_s == WR_BEAT) ?
                            d_wdata[wr_cnt_next_s*BEAT_BITS +: BEAT_BITS] : {BEAT_BITS{1'b0}};
            i_resp_r     <= (next_state_s == RESP) && (last_grant_r == ICACHE);
            d_resp_r     <= (next_state_s == RESP) && (last_grant_r == DCACHE);
        end
    end

    assign bmem_addr  = bmem_addr_r;
    assign bmem_read  = bmem_read_r;
    assign bmem_write = bmem_write_r;
    assign bmem_wdata = bmem_wdata_r;
    assign i_resp     = i_resp_r;
    assign d_resp     = d_resp_r;
    assign i_rdata    = i_resp_r ? line_s : {LINE_BITS{1'b0}};
    assign d_rdata    = (d_resp_r && !op_write_r) ? line_s : {LINE_BITS{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr, d_addr, bmem_addr;
    logic        i_read, i_resp, d_read, d_write, d_resp;
    line_t       i_rdata, d_rdata, d_wdata;
    logic        bmem_read, bmem_write, bmem_ready, bmem_rvalid;
    beat_t       bmem_wdata, bmem_rdata;
    logic        proto_err;

    int total = 0;
    int bad   = 0;

    line_t L1, L2, L3, W;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_rdata(bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    mem_port_arbiter_chk u_chk (
        .clk(clk), .rst(rst), .d_read(d_read), .d_write(d_write), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive rvalid per pattern bit; valid beats are taken from ln in slot order.
    task automatic feed(input string tag, input line_t ln, input logic [15:0] pat, input int n);
        int b = 0;
        for (int k = 0; k < n; k++) begin
            bmem_rvalid = pat[k];
            bmem_rdata  = pat[k] ? ln[b*64 +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
            if (pat[k]) b++;
            tick;
            if (k < n - 1) chk({tag, "_early"}, {i_resp, d_resp}, 2'b00);
        end
        bmem_rvalid = 1'b0;
        bmem_rdata  = 64'h0;
    endtask

    // Full read from IDLE with the request already driven and memory always ready.
    task automatic read_txn(input string tag, input logic is_d, input logic [31:0] exp_addr,
                            input line_t ln);
        tick;
        chk({tag, "_addr"}, bmem_addr, exp_addr);
        chk({tag, "_cmd"}, bmem_read, 1'b1);
        tick;
        chk({tag, "_cmd_drop"}, bmem_read, 1'b0);
        feed(tag, ln, 16'h000F, 4);
        chk({tag, "_resp"}, {i_resp, d_resp}, is_d ? 2'b01 : 2'b10);
        chk({tag, "_rdata"}, is_d ? d_rdata : i_rdata, ln);
        chk({tag, "_other"}, is_d ? i_rdata : d_rdata, 256'h0);
    endtask

    initial begin
        L1 = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
        L2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
        L3 = {64'hCAFE_0003_CAFE_0003, 64'hCAFE_0002_CAFE_0002,
              64'hCAFE_0001_CAFE_0001, 64'hCAFE_0000_CAFE_0000};
        W  = {{4{16'hD3D3}}, {4{16'hC2C2}}, {4{16'hB1B1}}, {4{16'hA0A0}}};
        rst = 1'b1; i_addr = 32'h0; i_read = 1'b0; d_addr = 32'h0; d_read = 1'b0;
        d_write = 1'b0; d_wdata = 256'h0; bmem_ready = 1'b0; bmem_rdata = 64'h0;
        bmem_rvalid = 1'b0;
        tick; tick;
        chk("rst_cmd", {bmem_read, bmem_write}, 2'b00);
        chk("rst_addr", bmem_addr, 32'h0);
        chk("rst_wdata", bmem_wdata, 64'h0);
        chk("rst_resp", {i_resp, d_resp}, 2'b00);
        chk("rst_rdata", {i_rdata, d_rdata} == 512'h0, 1'b1);
        rst = 1'b0;
        bmem_ready = 1'b1;

        // icache read only
        i_addr = 32'h6000_001C; i_read = 1'b1;
        read_txn("t1", 1'b0, 32'h6000_0000, L1);
        i_read = 1'b0;
        tick;
        chk("t1_pulse", {i_resp, d_resp}, 2'b00);
        chk("t1_rdata_clr", i_rdata, 256'h0);

        // simultaneous reads from reset, then again after dcache service
        rst = 1'b1; tick; rst = 1'b0;
        i_addr = 32'h1000_0020; d_addr = 32'h2000_0044; i_read = 1'b1; d_read = 1'b1;
        read_txn("t2_i1", 1'b0, 32'h1000_0020, L2);
        i_read = 1'b0;
        tick;
        read_txn("t2_d1", 1'b1, 32'h2000_0040, L3);
        i_addr = 32'h1000_1000; d_addr = 32'h2000_3FFF; i_read = 1'b1;
        tick;
        read_txn("t2_i2", 1'b0, 32'h1000_1000, L1);
        i_read = 1'b0;
        tick;
        read_txn("t2_d2", 1'b1, 32'h2000_3FE0, L2);
        d_read = 1'b0;
        tick;

        // dcache write with ready low for 3 cycles on beat 2
        d_addr = 32'h8000_0047; d_wdata = W; d_write = 1'b1;
        tick;
        chk("t3_write", {bmem_write, bmem_read}, 2'b10);
        chk("t3_addr", bmem_addr, 32'h8000_0040);
        chk("t3_b0", bmem_wdata, W[63:0]);
        tick;
        chk("t3_b1", bmem_wdata, W[127:64]);
        tick;
        chk("t3_b2", bmem_wdata, W[191:128]);
        bmem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("t3_b2_hold", bmem_wdata, W[191:128]);
            chk("t3_hold_write", {bmem_write, d_resp}, 2'b10);
        end
        bmem_ready = 1'b1;
        tick;
        chk("t3_b3", bmem_wdata, W[255:192]);
        tick;
        chk("t3_resp", {d_resp, i_resp, bmem_write}, 3'b100);
        chk("t3_rdata_zero", d_rdata, 256'h0);
        d_write = 1'b0;
        tick;
        chk("t3_pulse", d_resp, 1'b0);

        // read with a stalled command and gapped rvalid 1,0,0,1,1,0,1
        i_addr = 32'h0000_ABCD; i_read = 1'b1; bmem_ready = 1'b0;
        tick;
        chk("t4_addr", bmem_addr, 32'h0000_ABC0);
        tick;
        chk("t4_cmd_hold", bmem_read, 1'b1);
        bmem_ready = 1'b1;
        tick;
        chk("t4_cmd_drop", bmem_read, 1'b0);
        feed("t4", L3, 16'h0059, 7);
        chk("t4_resp", {i_resp, d_resp}, 2'b10);
        chk("t4_rdata", i_rdata, L3);
        i_read = 1'b0;
        tick;

        // reset after two read beats, stray beats, then a fresh read
        i_addr = 32'h4000_1234; i_read = 1'b1;
        tick; tick;
        feed("t5", L1, 16'h0003, 2);
        chk("t5_addr_pre", bmem_addr, 32'h4000_1220);
        rst = 1'b1; i_read = 1'b0;
        #1;
        chk("t5_async_addr", bmem_addr, 32'h0);
        chk("t5_async_out", {bmem_read, bmem_write, i_resp, d_resp}, 4'b0000);
        tick;
        rst = 1'b0;
        feed("t5s", L2, 16'h0003, 2);
        chk("t5_stray_resp", {i_resp, d_resp}, 2'b00);
        chk("t5_stray_cmd", bmem_read, 1'b0);
        i_addr = 32'h4000_2000; i_read = 1'b1;
        read_txn("t5f", 1'b0, 32'h4000_2000, L2);
        i_read = 1'b0;
        tick;

        // d_read and d_write together: write wins, flagged by the monitor
        chk("t6_flag_clear", proto_err, 1'b0);
        d_addr = 32'h9000_0010; d_wdata = W; d_read = 1'b1; d_write = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("t6_write", {bmem_write, bmem_read}, 2'b10);
            chk("t6_beat", bmem_wdata, W[k*64 +: 64]);
        end
        tick;
        chk("t6_resp", {d_resp, bmem_read}, 2'b10);
        chk("t6_flag", proto_err, 1'b1);
        d_read = 1'b0; d_write = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single burst-memory port between the instruction cache (fetch miss path, read-only) and the data cache (read and writeback).
- Converts each 256-bit line request into a 4-beat, 64-bit burst and reassembles read beats into a line.
- Returns exactly one response pulse to the requester that was granted.
- Sits below both caches, in front of the memory model/adapter.

Parameters:
- LINE_BITS, 256, cache line width in bits.
- BEAT_BITS, 64, burst beat width; BEATS = LINE_BITS/BEAT_BITS = 4 (derived localparam).
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_addr  in  ADDR_WIDTH  icache line address.
- i_read  in  1  icache read request; held until i_resp.
- i_rdata  out  LINE_BITS  icache line data; valid only while i_resp is high.
- i_resp  out  1  one-cycle completion pulse to the icache.
- d_addr  in  ADDR_WIDTH  dcache line address.
- d_read  in  1  dcache read request; held until d_resp.
- d_write  in  1  dcache writeback request; held until d_resp.
- d_wdata  in  LINE_BITS  writeback line; stable while d_write is high.
- d_rdata  out  LINE_BITS  dcache line data; valid only while d_resp is high.
- d_resp  out  1  one-cycle completion pulse to the dcache.
- bmem_addr  out  ADDR_WIDTH  burst address, always 32-byte aligned.
- bmem_read  out  1  read command; one cycle.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  BEAT_BITS  write beat data.
- bmem_ready  in  1  memory accepts a command or beat this cycle.
- bmem_rdata  in  BEAT_BITS  read beat data.
- bmem_rvalid  in  1  read beat valid.

Behaviour:
- Reset:
  - state=IDLE, beat_cnt=0, last_grant=DCACHE, so the icache wins the first tie.
  - All outputs 0 (rdata buses 0).
  - Reset mid-burst abandons the transaction. Read beats arriving after reset are ignored because IDLE discards bmem_rvalid.
- States: IDLE, RD_CMD, RD_WAIT, WR_BEAT, RESP.
- IDLE arbitration:
  - Requests considered: i_read, d_read|d_write.
  - If both are pending, grant the requester not in last_grant (round robin).
  - Latch the grantee, the operation, and addr with bits [4:0] forced to 0.
  - Update last_grant and go to RD_CMD or WR_BEAT next cycle. There is no same-cycle grant-to-command path.
  - d_read and d_write both high: write wins; the read is not performed (protocol violation, flagged by an assertion).
- RD_CMD:
  - Drive bmem_addr and bmem_read=1.
  - When bmem_ready=1, go to RD_WAIT with beat_cnt=0.
  - If bmem_ready=0, hold the command.
- RD_WAIT:
  - Each cycle with bmem_rvalid=1, store bmem_rdata into line slice [beat_cnt*64 +: 64] and increment beat_cnt.
  - On the 4th beat, go to RESP.
  - Beats need not be consecutive.
- WR_BEAT:
  - bmem_write=1, bmem_addr=latched address, bmem_wdata=d_wdata slice [beat_cnt*64 +: 64].
  - beat_cnt advances only when bmem_ready=1. With bmem_ready=0, hold the same beat.
  - When beat 3 is accepted, go to RESP.
- RESP:
  - Exactly one cycle. Assert the grantee's resp.
  - Drive the assembled line on its rdata; for writes rdata is don't-care, driven 0.
  - Next state is IDLE; requests are sampled again starting the cycle after RESP.
  - A requester seeing resp deasserts or changes its request on the following edge.
- Resp and rdata of the non-granted requester are always 0.
- At most one transaction is outstanding; there is no cancellation. A fetch flush on branch mispredict does not abort an icache read; the icache discards stale data itself.
- beat_cnt is 2 bits and wraps 3->0. It is cleared on entry to RD_WAIT and WR_BEAT.
- Latency from request to resp, with an always-ready memory and rvalid arriving N cycles after the command:
  - read = 1 (IDLE) + 1 (RD_CMD) + N + 4 + 1 cycles;
  - write = 1 + 4 + 1 = 6 cycles.

Decomposition:
- Shared package gets:
  - enum arb_state_t {IDLE, RD_CMD, RD_WAIT, WR_BEAT, RESP};
  - enum requester_t {ICACHE, DCACHE};
  - line_t / beat_t typedefs.
- One sub-module is natural: line_deserializer (beat_cnt plus the 256-bit shift/slot register, with a clear and load-beat interface), instantiated once.
- Write serialization stays inline as a mux on beat_cnt.

Test Plan:
- Icache read only:
  - Stimulus: i_addr=0x6000_001C, memory returns beats 0x11..,0x22..,0x33..,0x44..
  - Required: bmem_addr=0x6000_0000; i_rdata={0x44..,0x33..,0x22..,0x11..}; one i_resp pulse; d_resp=0 throughout.
- Simultaneous i_read and d_read from reset:
  - Required: icache served first, then dcache.
  - Then both again: icache served first again, because last_grant=DCACHE after the dcache service.
- Dcache write, bmem_ready low on beat 2 for 3 cycles:
  - Required: beat 2 is held on bmem_wdata unchanged; exactly 4 accepted beats, in order; d_resp follows 1 cycle after the last accepted beat.
- Read with gapped rvalid:
  - Stimulus: rvalid pattern 1,0,0,1,1,0,1.
  - Required: beats land in slots 0-3 correctly; resp appears 1 cycle after the 4th beat.
- Reset asserted after 2 read beats:
  - Required: all outputs 0 immediately (async); 2 stray rvalid beats afterwards produce no resp.
  - Then a fresh i_read completes normally.
- d_read and d_write both high:
  - Required: a write burst occurs, no bmem_read is issued, and the assertion fires.
